sys_arr_feeder: RTL

- Operand staging and skew stage directly upstream of sys_array.
- Accepts matrix A (MxN) and matrix B (NxK) as a single-word load stream and buffers both completely.
- Then drives the west edge (A rows) and north edge (B columns) of the array with diagonally skewed single_float operands and per-lane valids.
- Pulses done once the last operand has left.

---
 rtl/dsp_sys_arr_pkg.sv | 28 ++
 rtl/sys_arr_feeder_if.sv | 42 ++++
 rtl/operand_skew_lane.sv | 75 +++++++
 rtl/sys_arr_feeder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// dsp_sys_arr_pkg: shared types and sizing helpers for the systolic-array
// datapath (operand feeder and array).
//   single_float   : IEEE-754 single-precision word as raw bits
//   feeder_state_t : feeder job phases IDLE -> LOAD -> STREAM -> DONE
//   stream_len()   : number of skewed steps needed to drain an MxN by NxK job
//   idx_w()        : index width for a count, never narrower than one bit
package dsp_sys_arr_pkg;

  typedef logic [31:0] single_float;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Lane i starts i steps late and carries N operands, so the last lane
  // (index max(M,K)-1) finishes on step N+max(M,K)-2.
  function automatic int stream_len(int m, int n, int k);
    return n + ((m > k) ? m : k) - 1;
  endfunction

  function automatic int idx_w(int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sys_arr_feeder_if.sv
// sys_arr_feeder_if: load stream, array-edge operands and job status of the
// operand feeder.
//   slave  modport : the feeder (drives ld_ready, operands, status, state)
//   master modport : the producer/consumer side (drives start, load word,
//                    arr_ready)
// Handshake: a load word moves on every rising edge where ld_valid and
// ld_ready are both high; ld_valid/ld_sel/ld_data must be stable across that
// edge. ld_ready does not depend combinationally on ld_valid. On the array
// side, arr_ready high lets the feeder advance one skew step on the edge;
// arr_ready low holds every operand and valid unchanged.
interface sys_arr_feeder_if
  import dsp_sys_arr_pkg::*;
#(
  parameter int M  = 2,
  parameter int K  = 2,
  parameter int DW = 32
);
  logic            start;
  logic            ld_valid;
  logic            ld_ready;
  logic            ld_sel;
  logic [DW-1:0]   ld_data;
  logic            arr_ready;
  logic [M*DW-1:0] a_out;
  logic [M-1:0]    a_valid;
  logic [K*DW-1:0] b_out;
  logic [K-1:0]    b_valid;
  logic            busy;
  logic            done;
  logic            error;
  feeder_state_t   state;     // debug view of the feeder FSM

  modport slave (
    input  start, ld_valid, ld_sel, ld_data, arr_ready,
    output ld_ready, a_out, a_valid, b_out, b_valid, busy, done, error, state
  );

  modport master (
    output start, ld_valid, ld_sel, ld_data, arr_ready,
    input  ld_ready, a_out, a_valid, b_out, b_valid, busy, done, error, state
  );
endinterface

// File: rtl/operand_skew_lane.sv
// operand_skew_lane: one west-edge row or north-edge column of the feeder.
// Holds the N operands of its lane and presents, on a registered output,
// the operand belonging to skew step step_i (word step_i-LANE), or zero with
// valid low when that step lies outside the lane's window.
//   clk_i, rst_ni     : clock, asynchronous active-low reset of the outputs
//   wr_en_i/idx/data  : buffer write port (one word per cycle)
//   load_i, step_i    : capture the operand for step step_i
//   clear_i           : zero data and valid (end of job)
//   data_o, valid_o   : registered operand and valid; held when idle
module operand_skew_lane
  import dsp_sys_arr_pkg::*;
#(
  parameter  int N    = 3,
  parameter  int DW   = 32,
  parameter  int LANE = 0,
  parameter  int TW   = 2,
  localparam int IW   = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [TW-1:0] step_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);
  logic [DW-1:0] buf_q [N];
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  int            rel;
  logic          in_win;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_word;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) buf_q[wr_idx_i] <= wr_data_i;
  end

  always_comb begin
    rel    = int'(step_i) - LANE;
    in_win = (rel >= 0) && (rel < N);
    rd_idx = IW'(rel);
    // Step 0 is captured on the same edge that writes the final load word,
    // so a word being written right now must bypass the buffer.
    rd_word = (wr_en_i && (wr_idx_i == rd_idx)) ? wr_data_i : buf_q[rd_idx];
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = in_win;
      data_d  = in_win ? rd_word : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: loads matrix A (MxN, row-major) then matrix B (NxK,
// row-major) from a single word stream, then drives the west (A rows) and
// north (B columns) edges of the systolic array with diagonally skewed
// operands and per-lane valids, and pulses done after the last step.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : sys_arr_feeder_if.slave (load stream, edge operands, status)
// Optional build macro FEEDER_LOAD_CHECK_EN: flags (sticky) any accepted
// load word whose ld_sel does not match the A-then-B order.
module sys_arr_feeder
  import dsp_sys_arr_pkg::*;
#(
  parameter int M  = 2,
  parameter int N  = 3,
  parameter int K  = 2,
  parameter int DW = 32
) (
  input logic             CLK,
  input logic             nRST,
  sys_arr_feeder_if.slave bus
);
  localparam int MN    = M * N;
  localparam int TOTAL = MN + N * K;
  localparam int SLEN  = stream_len(M, N, K);
  localparam int CW    = idx_w(TOTAL);
  localparam int TW    = idx_w(SLEN);
  localparam int IW    = idx_w(N);
  localparam logic [CW-1:0] LAST_WORD = CW'(TOTAL - 1);
  localparam logic [TW-1:0] LAST_STEP = TW'(SLEN - 1);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [TW-1:0] t_q, t_d;
  logic          accept;
  logic          lane_load, lane_clear;
  logic [TW-1:0] lane_step;

  assign accept = (state_q == LOAD) && bus.ld_valid;

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    t_d        = t_q;
    lane_load  = 1'b0;
    lane_clear = 1'b0;
    lane_step  = t_q + TW'(1);
    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: if (accept) begin
        if (ld_cnt_q == LAST_WORD) begin
          state_d   = STREAM;
          ld_cnt_d  = '0;
          t_d       = '0;
          lane_load = 1'b1;
          lane_step = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + CW'(1);
        end
      end
      STREAM: if (bus.arr_ready) begin
        if (t_q == LAST_STEP) begin
          state_d    = DONE;
          t_d        = '0;
          lane_clear = 1'b1;
        end else begin
          t_d       = t_q + TW'(1);
          lane_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
    end
  end

  logic [DW-1:0] a_data [M];
  logic          a_vld  [M];
  logic [DW-1:0] b_data [K];
  logic          b_vld  [K];

  // A word w < M*N is A[w/N][w%N]: lane w/N, slot w%N.
  for (genvar gi = 0; gi < M; gi++) begin : g_a
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    always_comb begin
      wr_en  = accept && (int'(ld_cnt_q) < MN) && ((int'(ld_cnt_q) / N) == gi);
      wr_idx = IW'(int'(ld_cnt_q) % N);
    end
    operand_skew_lane #(.N(N), .DW(DW), .LANE(gi), .TW(TW)) u_lane (
      .clk_i(CLK), .rst_ni(nRST), .wr_en_i(wr_en), .wr_idx_i(wr_idx),
      .wr_data_i(bus.ld_data), .load_i(lane_load), .clear_i(lane_clear),
      .step_i(lane_step), .data_o(a_data[gi]), .valid_o(a_vld[gi])
    );
  end

  // B word r = w-M*N is B[r/K][r%K]: lane r%K, slot r/K.
  for (genvar gj = 0; gj < K; gj++) begin : g_b
    int            rel;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    always_comb begin
      rel    = int'(ld_cnt_q) - MN;
      wr_en  = accept && (rel >= 0) && ((rel % K) == gj);
      wr_idx = IW'(rel / K);
    end
    operand_skew_lane #(.N(N), .DW(DW), .LANE(gj), .TW(TW)) u_lane (
      .clk_i(CLK), .rst_ni(nRST), .wr_en_i(wr_en), .wr_idx_i(wr_idx),
      .wr_data_i(bus.ld_data), .load_i(lane_load), .clear_i(lane_clear),
      .step_i(lane_step), .data_o(b_data[gj]), .valid_o(b_vld[gj])
    );
  end

  always_comb begin
    bus.a_out   = '0;
    bus.a_valid = '0;
    bus.b_out   = '0;
    bus.b_valid = '0;
    for (int i = 0; i < M; i++) begin
      bus.a_out[i*DW +: DW] = a_data[i];
      bus.a_valid[i]        = a_vld[i];
    end
    for (int j = 0; j < K; j++) begin
      bus.b_out[j*DW +: DW] = b_data[j];
      bus.b_valid[j]        = b_vld[j];
    end
  end

  assign bus.ld_ready = (state_q == LOAD);
  assign bus.busy     = (state_q == LOAD) || (state_q == STREAM);
  assign bus.done     = (state_q == DONE);
  assign bus.state    = state_q;

`ifdef FEEDER_LOAD_CHECK_EN
  logic error_q;
  logic exp_sel;
  assign exp_sel = (int'(ld_cnt_q) >= MN);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) error_q <= 1'b0;
    else if (accept && (bus.ld_sel != exp_sel)) error_q <= 1'b1;
  end
  assign bus.error = error_q;
`else
  logic unused_ld_sel;
  assign unused_ld_sel = bus.ld_sel;
  assign bus.error     = 1'b0;
`endif
endmodule
